stream_fifo_int16: RTL and testbench
====================================

Name: stream_fifo_int16

Overview:
- Elastic buffer that sits directly downstream of the fixed-latency INT16 delay nodes.
- Converts their free-running, non-stallable output into a valid/ready stream for consumers that can apply backpressure.
- The upstream delay stage cannot stall, so writes presented while full are dropped and flagged.
- Depth is a parameter; the data width is fixed at 16 bits to match the INT16 node family.

Parameters:
- DEPTH, 4, number of 16-bit entries; must be a power of two, >= 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- in  input  16  write data, from the upstream delay node's out.
- in_valid  input  1  write strobe, aligned with in (the upstream valid shifted by the same latency).
- in_ready  output  1  FIFO can accept a write this cycle.
- out  output  16  head-of-queue data.
- out_valid  output  1  out holds a valid entry.
- out_ready  input  1  consumer accepts out this cycle.
- level  output  AW+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a write was dropped while full.
- overflow_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (reset=0, asynchronous):
  - write pointer, read pointer and level go to 0; overflow goes to 0.
  - out_valid=0 and in_ready=1 while reset is held; out is don't-care.
  - Storage contents are not reset.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (level != DEPTH). It is combinational from registered level and does not depend on out_ready, so there is no full-bypass.
- out_valid = (level != 0). out is read combinationally from storage at the read pointer.
- Latency: a word pushed into an empty FIFO at edge N is visible with out_valid=1 in the cycle after edge N. There is no same-cycle fall-through.
- Pointers wrap modulo DEPTH using natural AW-bit overflow.
- Level update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged; the write lands at the write pointer and the read advances.
- When full with out_ready=1: the pop occurs, but in_ready=0, so an in_valid in the same cycle is dropped. in_ready returns to 1 in the next cycle.
- Overflow: set on any cycle with in_valid=1 and in_ready=0. Set has priority over overflow_clr in the same cycle. The dropped data is never written.
- Empty with out_ready=1: no effect, and the read pointer does not move.
- Ordering is strict FIFO; no reordering, no duplication.
- Reset asserted mid-operation discards all entries immediately. After release, the first push lands in slot 0.

Decomposition:
- Shared package (alongside the other INT16 node definitions) holds:
  - INT16_W = 16, the common data-width constant.
  - A default FIFO depth constant.
- One natural sub-module: stream_fifo_mem, a DEPTH x 16 register array with one write port and one asynchronous read port.
- Pointer, level and flag logic stays in the top module.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_valid=1 -> out_valid=0, level=0, in_ready=1, overflow=0; after release, nothing from the reset window appears at out.
- Fill/drain, DEPTH=4: push 0x0001..0x0004 with out_ready=0 -> level=4 and in_ready=0. Then out_ready=1 -> out reads 0x0001, 0x0002, 0x0003, 0x0004 on consecutive cycles, and level counts 3,2,1,0.
- Overflow: with the FIFO full, drive in=0xBEEF, in_valid=1, out_ready=0 -> overflow=1 next cycle. Drain shows no 0xBEEF. Pulse overflow_clr -> overflow=0.
- Simultaneous push/pop at level 2: stream 0x0010..0x001F continuously with out_ready=1 -> level stays 2 throughout, and the output sequence equals the input sequence delayed by 2 words.
- Wrap-around: run 3xDEPTH+1 words with random out_ready (seeded) against a scoreboard -> no loss, no duplication, and overflow=0 whenever the driver honours in_ready.
- Reset mid-stream: assert reset with level=3 -> out_valid falls immediately (asynchronously). After release, push 0x1234 -> out=0x1234 with level=1.

Source files
------------

// File: rtl/stream_fifo_int16_pkg.sv
// Shared definitions for the INT16 node family: data width and default FIFO depth.
package stream_fifo_int16_pkg;

    localparam int unsigned INT16_W            = 16;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/stream_fifo_mem.sv
// DEPTH x INT16 register array: one synchronous write port, one asynchronous read port.
module stream_fifo_mem
    import stream_fifo_int16_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                       clock,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [INT16_W-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [INT16_W-1:0]         rdata
);

    logic [INT16_W-1:0] mem [DEPTH];

    // Storage is intentionally not reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo_int16.sv
// Elastic valid/ready buffer behind the non-stallable INT16 delay nodes; drops and flags writes while full.
module stream_fifo_int16
    import stream_fifo_int16_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [INT16_W-1:0]         in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [INT16_W-1:0]         out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       overflow_clr
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned LEVEL_W = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // No full-bypass: in_ready only looks at the registered level.
    assign in_ready  = (level != LEVEL_W'(DEPTH));
    assign out_valid = (level != LEVEL_W'(0));
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    stream_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clock (clock),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in),
        .raddr (rd_ptr),
        .rdata (out)
    );

    // Pointers wrap naturally at AW bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            level <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Sticky drop flag; a new drop wins over a same-cycle clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_fifo_int16.sv
// Directed bench for stream_fifo_int16 (DEPTH=4): vector table plus reset, streaming, wrap and mid-stream reset sequences.
module tb_stream_fifo_int16;
    import stream_fifo_int16_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  level;
    logic        overflow;
    logic        overflow_clr;

    int vectors    = 0;
    int miscompares = 0;

    stream_fifo_int16 #(.DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .in           (in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out          (out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .level        (level),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] din;
        logic        vld;
        logic        ordy;
        logic        clr;
        logic        e_ovld;
        logic [15:0] e_out;
        logic [2:0]  e_lvl;
        logic        e_ir;
        logic        e_ovf;
    } vec_t;

    function automatic vec_t mk(logic [15:0] din, logic vld, logic ordy, logic clr,
                                logic e_ovld, logic [15:0] e_out, logic [2:0] e_lvl,
                                logic e_ir, logic e_ovf);
        vec_t v;
        v.din = din;  v.vld = vld;  v.ordy = ordy;  v.clr = clr;
        v.e_ovld = e_ovld;  v.e_out = e_out;  v.e_lvl = e_lvl;
        v.e_ir = e_ir;  v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        in           = v.din;
        in_valid     = v.vld;
        out_ready    = v.ordy;
        overflow_clr = v.clr;
    endtask

    // Compares state-derived outputs against expectation; out only checked when valid.
    task automatic check(input string name, input vec_t v);
        logic bad;
        bad = (out_valid !== v.e_ovld) || (level !== v.e_lvl) ||
              (in_ready !== v.e_ir) || (overflow !== v.e_ovf) ||
              (v.e_ovld && (out !== v.e_out));
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL %s: got ov=%0b out=%h lvl=%0d ir=%0b ovf=%0b, want ov=%0b out=%h lvl=%0d ir=%0b ovf=%0b",
                     name, out_valid, out, level, in_ready, overflow,
                     v.e_ovld, v.e_out, v.e_lvl, v.e_ir, v.e_ovf);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0b, want %0b", name, got, want);
        end
    endtask

    vec_t tbl [24];

    initial begin
        // Table: fill/drain, overflow with clear, full+pop drop, set-over-clear priority.
        // Each entry: inputs applied this cycle, outputs expected before the next edge.
        tbl[0]  = mk(16'h0001, 1, 0, 0,  0, 16'h0000, 3'd0, 1, 0);
        tbl[1]  = mk(16'h0002, 1, 0, 0,  1, 16'h0001, 3'd1, 1, 0);
        tbl[2]  = mk(16'h0003, 1, 0, 0,  1, 16'h0001, 3'd2, 1, 0);
        tbl[3]  = mk(16'h0004, 1, 0, 0,  1, 16'h0001, 3'd3, 1, 0);
        tbl[4]  = mk(16'hBEEF, 1, 0, 0,  1, 16'h0001, 3'd4, 0, 0);
        tbl[5]  = mk(16'h0000, 0, 1, 0,  1, 16'h0001, 3'd4, 0, 1);
        tbl[6]  = mk(16'h0000, 0, 1, 0,  1, 16'h0002, 3'd3, 1, 1);
        tbl[7]  = mk(16'h0000, 0, 1, 0,  1, 16'h0003, 3'd2, 1, 1);
        tbl[8]  = mk(16'h0000, 0, 1, 1,  1, 16'h0004, 3'd1, 1, 1);
        tbl[9]  = mk(16'h0000, 0, 1, 0,  0, 16'h0000, 3'd0, 1, 0);
        tbl[10] = mk(16'h00A1, 1, 0, 0,  0, 16'h0000, 3'd0, 1, 0);
        tbl[11] = mk(16'h00A2, 1, 0, 0,  1, 16'h00A1, 3'd1, 1, 0);
        tbl[12] = mk(16'h00A3, 1, 0, 0,  1, 16'h00A1, 3'd2, 1, 0);
        tbl[13] = mk(16'h00A4, 1, 0, 0,  1, 16'h00A1, 3'd3, 1, 0);
        tbl[14] = mk(16'hDEAD, 1, 1, 0,  1, 16'h00A1, 3'd4, 0, 0);
        tbl[15] = mk(16'h0000, 0, 0, 1,  1, 16'h00A2, 3'd3, 1, 1);
        tbl[16] = mk(16'h00A5, 1, 0, 0,  1, 16'h00A2, 3'd3, 1, 0);
        tbl[17] = mk(16'h0BAD, 1, 0, 1,  1, 16'h00A2, 3'd4, 0, 0);
        tbl[18] = mk(16'h0000, 0, 1, 0,  1, 16'h00A2, 3'd4, 0, 1);
        tbl[19] = mk(16'h0000, 0, 1, 0,  1, 16'h00A3, 3'd3, 1, 1);
        tbl[20] = mk(16'h0000, 0, 1, 0,  1, 16'h00A4, 3'd2, 1, 1);
        tbl[21] = mk(16'h0000, 0, 1, 0,  1, 16'h00A5, 3'd1, 1, 1);
        tbl[22] = mk(16'h0000, 0, 0, 1,  0, 16'h0000, 3'd0, 1, 1);
        tbl[23] = mk(16'h0000, 0, 0, 0,  0, 16'h0000, 3'd0, 1, 0);

        // Reset held with writes presented: nothing may enter.
        reset = 1'b0;
        apply(mk(16'h7777, 1, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) begin
            @(negedge clock);
            check("reset_hold", mk(0, 0, 0, 0, 0, 16'h0000, 3'd0, 1, 0));
        end
        apply(mk(16'h0000, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        @(negedge clock);
        check("reset_release", mk(0, 0, 0, 0, 0, 16'h0000, 3'd0, 1, 0));

        for (int i = 0; i < 24; i++) begin
            @(negedge clock);
            apply(tbl[i]);
            check($sformatf("tbl[%0d]", i), tbl[i]);
        end

        // Continuous push/pop at level 2: output trails input by two words.
        @(negedge clock);
        apply(mk(16'h0010, 1, 0, 0, 0, 0, 0, 0, 0));
        check("stream_pre0", mk(0, 0, 0, 0, 0, 16'h0000, 3'd0, 1, 0));
        @(negedge clock);
        apply(mk(16'h0011, 1, 0, 0, 0, 0, 0, 0, 0));
        check("stream_pre1", mk(0, 0, 0, 0, 1, 16'h0010, 3'd1, 1, 0));
        for (int k = 16'h12; k <= 16'h1F; k++) begin
            @(negedge clock);
            apply(mk(16'(k), 1, 1, 0, 0, 0, 0, 0, 0));
            check($sformatf("stream_%0h", k), mk(0, 0, 0, 0, 1, 16'(k - 2), 3'd2, 1, 0));
        end
        @(negedge clock);
        apply(mk(16'h0000, 0, 1, 0, 0, 0, 0, 0, 0));
        check("stream_tail0", mk(0, 0, 0, 0, 1, 16'h001E, 3'd2, 1, 0));
        @(negedge clock);
        check("stream_tail1", mk(0, 0, 0, 0, 1, 16'h001F, 3'd1, 1, 0));
        @(negedge clock);
        apply(mk(16'h0000, 0, 0, 0, 0, 0, 0, 0, 0));
        check("stream_empty", mk(0, 0, 0, 0, 0, 16'h0000, 3'd0, 1, 0));

        // Wrap-around against a queue model with LFSR-driven backpressure.
        begin
            logic [15:0] model [$];
            logic [15:0] lfsr;
            int          sent;
            int          cyc;
            logic        do_pop;
            lfsr = 16'hACE1;
            sent = 0;
            cyc  = 0;
            while ((sent < 3 * DEPTH + 1 || model.size() != 0) && cyc < 400) begin
                @(negedge clock);
                cyc++;
                vectors++;
                if ((out_valid !== (model.size() != 0)) || (level !== 3'(model.size())) ||
                    (in_ready !== (model.size() != DEPTH)) ||
                    (out_valid && model.size() != 0 && out !== model[0])) begin
                    miscompares++;
                    $display("FAIL wrap_cyc%0d: got ov=%0b out=%h lvl=%0d ir=%0b, want lvl=%0d head=%h",
                             cyc, out_valid, out, level, in_ready, model.size(),
                             (model.size() != 0) ? model[0] : 16'h0000);
                end
                do_pop = lfsr[0];
                lfsr   = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
                out_ready    = do_pop;
                overflow_clr = 1'b0;
                in_valid     = (sent < 3 * DEPTH + 1) && in_ready;
                in           = 16'h3000 + 16'(sent);
                if (do_pop && model.size() != 0) begin
                    void'(model.pop_front());
                end
                if (in_valid) begin
                    model.push_back(in);
                    sent++;
                end
            end
            check_bit("wrap_timeout", cyc < 400, 1'b1);
            @(negedge clock);
            apply(mk(16'h0000, 0, 0, 0, 0, 0, 0, 0, 0));
            check_bit("wrap_no_overflow", overflow, 1'b0);
            check_bit("wrap_drained", out_valid, 1'b0);
        end

        // Mid-stream reset at level 3, then first push after release.
        @(negedge clock);
        apply(mk(16'h0041, 1, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        apply(mk(16'h0042, 1, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        apply(mk(16'h0043, 1, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        apply(mk(16'h0000, 0, 0, 0, 0, 0, 0, 0, 0));
        check("mid_pre_reset", mk(0, 0, 0, 0, 1, 16'h0041, 3'd3, 1, 0));
        #2 reset = 1'b0;
        #1 check("mid_async_reset", mk(0, 0, 0, 0, 0, 16'h0000, 3'd0, 1, 0));
        @(negedge clock);
        reset = 1'b1;
        apply(mk(16'h1234, 1, 0, 0, 0, 0, 0, 0, 0));
        check("mid_release", mk(0, 0, 0, 0, 0, 16'h0000, 3'd0, 1, 0));
        @(negedge clock);
        apply(mk(16'h0000, 0, 0, 0, 0, 0, 0, 0, 0));
        check("mid_first_push", mk(0, 0, 0, 0, 1, 16'h1234, 3'd1, 1, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want completion before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
